// File: rtl/sum_acc_pkg.sv
// Shared types and width helpers for the sum accumulator.
package sum_acc_pkg;

   // Window control states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_e;

   localparam int unsigned DEF_T_WIDTH   = 14;
   localparam int unsigned DEF_N_SAMPLES = 8;

   // Shift that turns a window total into its mean.
   function automatic int unsigned avg_shift(input int unsigned n_samples);
      return $clog2(n_samples);
   endfunction

   // Total width: N samples of (2^(t+1)-1) cannot exceed t+1+log2(N) bits.
   function automatic int unsigned acc_width(input int unsigned t_width,
                                             input int unsigned n_samples);
      return t_width + 1 + $clog2(n_samples);
   endfunction

   // Sample counter must be able to hold N itself.
   function automatic int unsigned cnt_width(input int unsigned n_samples);
      return $clog2(n_samples) + 1;
   endfunction

   localparam int unsigned DEF_ACC_WIDTH = acc_width(DEF_T_WIDTH, DEF_N_SAMPLES);

endpackage

// File: rtl/sum_acc_fsm.sv
// Window control: tracks state and sample count, drives handshakes and
// tells the datapath when to load, add or clear the accumulator.
module sum_acc_fsm
   import sum_acc_pkg::*;
#(
   parameter int unsigned N_SAMPLES = DEF_N_SAMPLES
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_valid,
   input  logic i_clear,
   input  logic i_ready,
   output logic o_ready,
   output logic o_valid,
   output logic o_load,
   output logic o_add,
   output logic o_clr
);

   localparam int unsigned CNT_W = cnt_width(N_SAMPLES);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;

   // State and count registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Next-state, count update and datapath strobes; clear overrides everything.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      o_ready = (state_q != HOLD);
      o_valid = (state_q == HOLD);
      o_load  = 1'b0;
      o_add   = 1'b0;
      o_clr   = 1'b0;
      if (i_clear) begin
         state_d = IDLE;
         count_d = '0;
         o_clr   = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (i_valid) begin
                  o_load  = 1'b1;
                  count_d = CNT_W'(1);
                  state_d = ACCUM;
               end
            end
            ACCUM: begin
               if (i_valid) begin
                  o_add   = 1'b1;
                  count_d = count_q + CNT_W'(1);
                  if (count_q == CNT_W'(N_SAMPLES - 1)) begin
                     state_d = HOLD;
                  end
               end
            end
            HOLD: begin
               // Incoming samples are ignored here; o_ready=0 backpressures them.
               if (i_ready) begin
                  state_d = IDLE;
                  count_d = '0;
                  o_clr   = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               count_d = '0;
               o_clr   = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates N_SAMPLES unsigned sums into a window total and mean, then
// holds the result until the downstream stage accepts it.
module sum_accumulator
   import sum_acc_pkg::*;
#(
   parameter int unsigned T_WIDTH   = DEF_T_WIDTH,
   parameter int unsigned N_SAMPLES = DEF_N_SAMPLES,
   localparam int unsigned ACC_WIDTH = acc_width(T_WIDTH, N_SAMPLES)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   input  logic [T_WIDTH:0]     i_sum,
   output logic                 o_ready,
   input  logic                 i_clear,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [ACC_WIDTH-1:0] o_acc,
   output logic [T_WIDTH:0]     o_avg
);

   localparam int unsigned SHIFT = avg_shift(N_SAMPLES);

   logic                 load, add, clr;
   logic [ACC_WIDTH-1:0] acc_q;
   logic [ACC_WIDTH-1:0] sum_ext;

   assign sum_ext = ACC_WIDTH'(i_sum);

   sum_acc_fsm #(
      .N_SAMPLES (N_SAMPLES)
   ) u_fsm (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_valid),
      .i_clear (i_clear),
      .i_ready (i_ready),
      .o_ready (o_ready),
      .o_valid (o_valid),
      .o_load  (load),
      .o_add   (add),
      .o_clr   (clr)
   );

   // Accumulator register: first sample loads, later samples add.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc_q <= '0;
      end else if (clr) begin
         acc_q <= '0;
      end else if (load) begin
         acc_q <= sum_ext;
      end else if (add) begin
         acc_q <= acc_q + sum_ext;
      end
   end

   // Results are only visible while holding; the mean is the upper bits of the total.
   always_comb begin
      o_acc = '0;
      o_avg = '0;
      if (o_valid) begin
         o_acc = acc_q;
         o_avg = acc_q[ACC_WIDTH-1:SHIFT];
      end
   end

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator (T_WIDTH=14, N_SAMPLES=8).
module tb_sum_accumulator;

   localparam int unsigned TW  = 14;
   localparam int unsigned NS  = 8;
   localparam int unsigned AW  = 18;

   logic          clk;
   logic          rst_n;
   logic          valid;
   logic [TW:0]   sum;
   logic          ready_o;
   logic          clear;
   logic          valid_o;
   logic          ready;
   logic [AW-1:0] acc_o;
   logic [TW:0]   avg_o;

   int n_tests;
   int n_fail;

   // Reference model: samples of the open window, plus the held total.
   int unsigned win_q[$];
   bit          m_hold;
   int unsigned m_total;

   sum_accumulator #(
      .T_WIDTH   (TW),
      .N_SAMPLES (NS)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (valid),
      .i_sum   (sum),
      .o_ready (ready_o),
      .i_clear (clear),
      .o_valid (valid_o),
      .i_ready (ready),
      .o_acc   (acc_o),
      .o_avg   (avg_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      win_q.delete();
      m_hold  = 1'b0;
      m_total = 0;
   endtask

   // One clock edge of the behavioural model, from the inputs just driven.
   task automatic model_step();
      int unsigned t;
      if (clear) begin
         win_q.delete();
         m_hold = 1'b0;
      end else if (m_hold) begin
         if (ready) begin
            m_hold = 1'b0;
            win_q.delete();
         end
      end else if (valid) begin
         win_q.push_back(int'(sum));
         if (win_q.size() == NS) begin
            t = 0;
            foreach (win_q[i]) t += win_q[i];
            m_total = t;
            m_hold  = 1'b1;
         end
      end
   endtask

   task automatic check_model(input string tag);
      check_eq({tag, ".ready"}, 32'(ready_o), 32'(!m_hold));
      check_eq({tag, ".valid"}, 32'(valid_o), 32'(m_hold));
      check_eq({tag, ".acc"},   32'(acc_o),   m_hold ? m_total : 0);
      check_eq({tag, ".avg"},   32'(avg_o),   m_hold ? m_total / NS : 0);
   endtask

   // Called just after a falling edge: drive, clock, then check at next falling edge.
   task automatic cyc(input logic v, input int unsigned s, input logic c, input logic r,
                      input string tag);
      valid = v;
      sum   = (TW+1)'(s);
      clear = c;
      ready = r;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model(tag);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      model_reset();
      rst_n = 1'b0;
      valid = 1'b0;
      sum   = '0;
      clear = 1'b0;
      ready = 1'b0;
      #3;
      check_eq("rst.ready", 32'(ready_o), 1);
      check_eq("rst.valid", 32'(valid_o), 0);
      check_eq("rst.acc",   32'(acc_o),   0);
      check_eq("rst.avg",   32'(avg_o),   0);
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back window of 90s.
      for (int i = 0; i < NS; i++) cyc(1'b1, 90, 1'b0, 1'b1, "b2b");
      check_eq("b2b.valid", 32'(valid_o), 1);
      check_eq("b2b.acc",   32'(acc_o),   720);
      check_eq("b2b.avg",   32'(avg_o),   90);
      cyc(1'b0, 0, 1'b0, 1'b1, "b2b_done");
      check_eq("b2b.pulse", 32'(valid_o), 0);

      // Full-scale samples must not wrap.
      for (int i = 0; i < NS; i++) cyc(1'b1, 32766, 1'b0, 1'b0, "max");
      check_eq("max.acc", 32'(acc_o), 262128);
      check_eq("max.avg", 32'(avg_o), 32766);
      cyc(1'b0, 0, 1'b0, 1'b1, "max_done");

      // Samples 1..8 with gaps, then stall with extra samples offered.
      for (int i = 1; i <= NS; i++) begin
         cyc(1'b1, i, 1'b0, 1'b0, "gap");
         cyc(1'b0, 777, 1'b0, 1'b0, "gap_idle");
      end
      for (int i = 0; i < 5; i++) begin
         check_eq("stall.acc",   32'(acc_o),   36);
         check_eq("stall.avg",   32'(avg_o),   4);
         check_eq("stall.ready", 32'(ready_o), 0);
         cyc(1'b1, 999, 1'b0, 1'b0, "stall");
      end
      cyc(1'b1, 999, 1'b0, 1'b1, "stall_rel");
      check_eq("stall.rel", 32'(valid_o), 0);

      // Clear mid-window drops the partial total and the same-cycle sample.
      for (int i = 0; i < 3; i++) cyc(1'b1, 100, 1'b0, 1'b1, "clr_pre");
      cyc(1'b1, 100, 1'b1, 1'b1, "clr");
      for (int i = 0; i < NS; i++) cyc(1'b1, 10, 1'b0, 1'b0, "clr_post");
      check_eq("clr.acc", 32'(acc_o), 80);
      cyc(1'b0, 0, 1'b0, 1'b1, "clr_done");

      // Asynchronous reset between edges mid-window.
      for (int i = 0; i < 5; i++) cyc(1'b1, 50, 1'b0, 1'b1, "ar_pre");
      valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_eq("ar.ready", 32'(ready_o), 1);
      check_eq("ar.valid", 32'(valid_o), 0);
      check_eq("ar.acc",   32'(acc_o),   0);
      check_eq("ar.avg",   32'(avg_o),   0);
      #1;
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < NS; i++) cyc(1'b1, 1, 1'b0, 1'b0, "ar_post");
      check_eq("ar.acc", 32'(acc_o), 8);
      check_eq("ar.avg", 32'(avg_o), 1);
      cyc(1'b0, 0, 1'b0, 1'b1, "ar_done");

      // Randomised traffic against the model.
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 9) < 7), $urandom_range(0, 32767),
             ($urandom_range(0, 19) == 0), ($urandom_range(0, 1) == 1), "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL have parameter T_WIDTH, default 14, operand width of the upstream adder; input sum is T_WIDTH+1 bits.
REQ-002 SHALL have parameter N_SAMPLES, default 8, samples per accumulation window; power of two, 2..256.
REQ-003 SHALL have derived localparam ACC_WIDTH = T_WIDTH+1+clog2(N_SAMPLES), default 18.
REQ-004 SHALL have port i_clk  input  1  single clock, rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_valid  input  1  upstream sum valid.
REQ-007 SHALL have port i_sum  input  T_WIDTH+1  unsigned sum from the adder stage.
REQ-008 SHALL have port o_ready  output  1  block can accept a sample this cycle.
REQ-009 SHALL have port i_clear  input  1  synchronous window abort.
REQ-010 SHALL have port o_valid  output  1  window result valid.
REQ-011 SHALL have port i_ready  input  1  downstream accepts result.
REQ-012 SHALL have port o_acc  output  ACC_WIDTH  window total.
REQ-013 SHALL have port o_avg  output  T_WIDTH+1  window mean.

Function
REQ-014 SHALL accept a sample on any rising edge where i_valid && o_ready.
REQ-015 SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-016 IDLE: o_ready=1; on accept, acc<=i_sum, count<=1, go ACCUM.
REQ-017 ACCUM: o_ready=1; on accept, acc<=acc+i_sum, count<=count+1; on the accept making count==N_SAMPLES, go HOLD.
REQ-018 HOLD: o_ready=0, o_valid=1; o_acc/o_avg stable until i_ready=1; on i_ready go IDLE, clear acc and count.
REQ-019 Latency: o_valid SHALL rise on the edge after the Nth accepted sample, i.e. the Nth accepting edge registers the final total.
REQ-020 o_avg SHALL equal o_acc >> clog2(N_SAMPLES), truncated, no rounding.
REQ-021 Accumulator SHALL never overflow; ACC_WIDTH covers N_SAMPLES x (2^(T_WIDTH+1)-1).
REQ-022 i_valid gaps in ACCUM SHALL hold state; count and acc unchanged.
REQ-023 i_clear=1 SHALL take priority over all events: next state IDLE, acc=0, count=0, o_valid=0; a same-cycle sample is dropped.
REQ-024 In HOLD, i_valid SHALL be ignored; no sample is lost because o_ready=0 signals backpressure.
REQ-025 o_acc and o_avg SHALL read 0 outside HOLD.

Reset
REQ-026 i_rst_n low SHALL asynchronously force state IDLE, acc=0, count=0, o_valid=0, o_acc=0, o_avg=0; o_ready=1 combinationally from IDLE.
REQ-027 Reset assertion mid-window or in HOLD SHALL discard the partial or pending result; first accept after release starts a new window.

Structure
REQ-028 Package sum_acc_pkg SHALL hold the state enum (IDLE, ACCUM, HOLD) and the clog2-based width constants.
REQ-029 Control SHALL be one sub-module sum_acc_fsm (state, count, o_ready, o_valid); datapath acc register stays in the top.

Verification (T_WIDTH=14, N_SAMPLES=8)
REQ-030 Eight back-to-back samples of 90 with i_ready=1 -> o_valid one edge after 8th, o_acc=720, o_avg=90, one cycle pulse, then IDLE.
REQ-031 Eight samples of 32766 -> o_acc=262128, o_avg=32766, no wrap.
REQ-032 Samples 1..8 with i_valid gaps, i_ready=0 for 5 cycles -> o_acc=36, o_avg=4, held stable 5 cycles, o_ready=0 throughout, extra i_valid ignored.
REQ-033 Three samples of 100, then i_clear with i_valid -> acc=0, IDLE; next eight samples of 10 give o_acc=80.
REQ-034 i_rst_n pulsed low between edges after 5 samples -> all outputs 0 immediately; eight samples of 1 after release give o_acc=8, o_avg=1.
